memory_access_unit: RTL
=======================

// Module: memory_access_unit
// PURPOSE
//   Initiator for the data port (port B) of main_memory. Accepts one load/store at a time
//   from the pipeline MEM stage over a valid/ready handshake, drives the memory's address,
//   write-data, write-enable and byte-enable inputs, and waits out the synchronous read
//   latency. Returns aligned, sign/zero-extended load data or store completion on a
//   valid/ready response channel. Flags misaligned and illegal accesses without touching memory.
// PARAMETERS
//   READ_LATENCY  1   cycles from memory sampling the address to read data valid (>=1)
// PORTS
//   clk              in   1   clock, all state on rising edge
//   rst              in   1   asynchronous, active-high reset
//   req_valid        in   1   request present
//   req_ready        out  1   unit idle; request accepted on req_valid & req_ready
//   req_write        in   1   1 = store, 0 = load
//   req_funct3       in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr         in   32  byte address
//   req_wdata        in   32  store data, right-justified
//   resp_valid       out  1   response present
//   resp_ready       in   1   response consumed on resp_valid & resp_ready
//   resp_rdata       out  32  extended load data (0 for stores and errors)
//   resp_error       out  1   misaligned address or illegal funct3
//   mem_address      out  32  to memory address_b
//   mem_write_data   out  32  to memory write_data_b, lane-replicated
//   mem_write_enable out  1   to memory write_enable_b
//   mem_byte_enable  out  4   to memory byte_enable_b
//   mem_read_data    in   32  from memory read_data_b
// BEHAVIOUR
//   Reset (async): state IDLE; resp_valid, resp_error, mem_write_enable = 0; resp_rdata,
//     mem_address, mem_write_data = 0; mem_byte_enable = 4'b0000; req_ready = 1 after reset.
//   FSM: IDLE -> ISSUE (legal accept) | RESP (illegal accept); ISSUE -> RESP (store) | WAIT (load);
//     WAIT -> RESP when latency counter reaches 0; RESP -> IDLE on resp_ready.
//   req_ready = (state == IDLE). Accept latches addr, funct3, write, wdata into registers.
//   mem_* outputs are driven from the latched registers. mem_write_enable = 1 and byte enables
//     are non-zero only in ISSUE. mem_address holds its last value otherwise.
//   Illegal: funct3 in {011,110,111}, or store with funct3 1xx; H with addr[0]=1;
//     W with addr[1:0]!=0. Response: RESP with resp_error=1, resp_rdata=0, no mem write.
//   Store lanes: B -> be = 4'b0001 << addr[1:0], wdata = {4{b}}; H -> be = addr[1] ? 1100 : 0011,
//     wdata = {2{h}}; W -> be = 1111.
//   Load: counter loads READ_LATENCY-1 on ISSUE->WAIT and decrements each cycle. mem_read_data
//     is captured on the WAIT edge where the count is 0. Lane is selected by addr[1:0]; B/H
//     are sign-extended and BU/HU zero-extended.
//   Latency (accept edge E0): store resp_valid from E0+2; load from E0+2+READ_LATENCY;
//     error from E0+1.
//   resp_valid, resp_rdata and resp_error hold stable while resp_ready=0. One transaction is
//     in flight at a time; the next accept is no earlier than the edge after the response handshake.
//   Reset mid-operation: mem_write_enable drops asynchronously, so a store in ISSUE is not
//     committed unless the edge precedes reset. The pending response is discarded.
// STRUCTURE
//   Shared header mem_defs.vh: funct3 width encodings, FSM state localparams.
//   One sub-module, load_data_extend: combinational lane select and extension
//     (mem_read_data, addr[1:0], funct3 -> 32-bit result).
//   Store lane steering and the latency counter live in the top module.
// TESTING (bench instantiates main_memory on the mem_* side)
//   1. SW 0x100 = 0xDEADBEEF, then LW 0x100 -> be=1111, resp_rdata=0xDEADBEEF at E0+3 (lat 1).
//   2. SB 0x103 = 0x000000A5 -> be=1000, write_data=0xA5A5A5A5. LB 0x103 -> 0xFFFFFFA5;
//      LBU 0x103 -> 0x000000A5.
//   3. SH 0x102 = 0x8001 -> be=1100. LH 0x102 -> 0xFFFF8001; LHU -> 0x00008001.
//      Bytes 0x100-0x101 unchanged.
//   4. LW 0x101, SH 0x103, funct3=011 -> resp_error=1 at E0+1, mem_write_enable never 1,
//      memory unchanged.
//   5. resp_ready low 5 cycles after load -> resp_valid/rdata stable, req_ready=0.
//      Release -> IDLE next edge. Repeat test 1 with READ_LATENCY=2 -> resp at E0+4.
//   6. Assert rst during ISSUE of SW 0x200 = 0x12345678 -> all outputs at reset values
//      immediately, word at 0x200 unchanged.

Source files
------------

// File: rtl/memory_access_unit_pkg.sv
// Shared types and encodings for the data-port memory access unit.
// Width decode helpers are used by both the top and the load extender.
package memory_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only make sense for loads.
    function automatic logic access_illegal(
        input logic       write,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        unique case (f3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = write;
            F3_H:    bad = off[0];
            F3_HU:   bad = write | off[0];
            F3_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b1111;
        unique case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_data(
        input logic [2:0]  f3,
        input logic [31:0] wdata
    );
        logic [31:0] d;
        d = wdata;
        unique case (f3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/memory_access_unit_load_data_extend.sv
// Picks the addressed byte/halfword lane out of a read word
// and sign- or zero-extends it to 32 bits.
module load_data_extend
    import memory_access_unit_pkg::*;
(
    input  logic [31:0] mem_read_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = mem_read_data >> {offset, 3'b000};
        b       = shifted[7:0];
        h       = offset[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        result  = mem_read_data;
        unique case (funct3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_BU:   result = {24'h0, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_HU:   result = {16'h0, h};
            default: result = mem_read_data;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Single-outstanding load/store initiator for the data port of main memory.
// Illegal requests bypass memory and answer straight from IDLE.
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_read_data
);

    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        write_q;
    logic [CW-1:0] cnt;
    logic [31:0] load_ext;
    logic        accept;
    logic        illegal;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign illegal   = access_illegal(req_write, req_funct3, req_addr[1:0]);

    load_data_extend u_ext (
        .mem_read_data (mem_read_data),
        .offset        (off_q),
        .funct3        (f3_q),
        .result        (load_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            f3_q             <= 3'b000;
            off_q            <= 2'b00;
            write_q          <= 1'b0;
            cnt              <= '0;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_rdata       <= 32'h0;
            mem_address      <= 32'h0;
            mem_write_data   <= 32'h0;
            mem_write_enable <= 1'b0;
            mem_byte_enable  <= 4'b0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        write_q <= req_write;
                        if (illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state            <= ISSUE;
                            mem_address      <= req_addr;
                            mem_write_data   <= lane_data(req_funct3, req_wdata);
                            mem_byte_enable  <= lane_mask(req_funct3, req_addr[1:0]);
                            mem_write_enable <= req_write;
                        end
                    end
                end
                ISSUE: begin
                    mem_write_enable <= 1'b0;
                    mem_byte_enable  <= 4'b0000;
                    if (write_q) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= 32'h0;
                    end else begin
                        state <= WAIT;
                        cnt   <= CW'(READ_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= load_ext;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
